// File: rtl/vec_dot_sequencer.sv
// Sequencer for the parallel vector multiplier: loads two LEN-element vectors, runs LANES
// multipliers for LEN/LANES cycles and hands out the dot product. Optional abort: VPM_ABORT_EN.
module vec_dot_sequencer #(
  parameter int unsigned LEN    = 8,
  parameter int unsigned LANES  = 2,
  parameter int unsigned ELEM_W = 9,
  parameter int unsigned ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ELEM_W-1:0] in_a,
  input  logic [ELEM_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data
`ifdef VPM_ABORT_EN
  ,
  input  logic              abort
`endif
);

  localparam int unsigned Steps = LEN / LANES;
  localparam int unsigned IW    = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int unsigned CW    = (Steps > 1) ? $clog2(Steps) : 1;
  localparam int unsigned PW    = 2 * ELEM_W;

  typedef enum logic [1:0] {StIdle, StLoad, StCompute, StDone} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cidx_q, cidx_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  out_data_q, out_data_d;
  logic [ELEM_W-1:0] buf_a_q [LEN];
  logic [ELEM_W-1:0] buf_b_q [LEN];
  logic              load_we;
  logic              abort_w;
  logic [ACC_W-1:0]  partial;
  logic [IW-1:0]     eidx;
  logic [PW-1:0]     prod;

`ifdef VPM_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Sum of this compute step's LANES products, each zero-extended to the accumulator width.
  always_comb begin
    partial = '0;
    eidx    = '0;
    prod    = '0;
    for (int j = 0; j < int'(LANES); j++) begin
      eidx    = IW'(int'(cidx_q) * int'(LANES) + j);
      prod    = PW'(buf_a_q[eidx]) * PW'(buf_b_q[eidx]);
      partial = partial + ACC_W'(prod);
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cidx_d     = cidx_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    load_we    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !abort_w) begin
          state_d = StLoad;
          idx_d   = '0;
          cidx_d  = '0;
          acc_d   = '0;
        end
      end
      StLoad: begin
        if (in_valid) begin
          load_we = 1'b1;
          idx_d   = idx_q + 1'b1;
          if (idx_q == IW'(LEN - 1)) begin
            state_d = StCompute;
            idx_d   = '0;
          end
        end
      end
      StCompute: begin
        acc_d  = acc_q + partial;
        cidx_d = cidx_q + 1'b1;
        if (cidx_q == CW'(Steps - 1)) begin
          state_d    = StDone;
          cidx_d     = '0;
          out_data_d = acc_q + partial;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Abort overrides everything, including a DONE handshake in the same cycle.
    if (abort_w && state_q != StIdle) begin
      state_d = StIdle;
      idx_d   = '0;
      cidx_d  = '0;
      acc_d   = '0;
      load_we = 1'b0;
      if (state_q == StDone) out_data_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      cidx_q     <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      buf_a_q    <= '{default: '0};
      buf_b_q    <= '{default: '0};
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cidx_q     <= cidx_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      if (load_we) begin
        buf_a_q[idx_q] <= in_a;
        buf_b_q[idx_q] <= in_b;
      end
    end
  end

  assign busy      = (state_q != StIdle);
  assign in_ready  = (state_q == StLoad);
  assign out_valid = (state_q == StDone);
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_vec_dot_sequencer.sv
// Self-checking bench for vec_dot_sequencer: directed runs compared every cycle against a
// phase/dot-product model, plus literal expectations. Abort run only with VPM_ABORT_EN.
module tb_vec_dot_sequencer;
  localparam int unsigned LEN    = 8;
  localparam int unsigned LANES  = 2;
  localparam int unsigned ELEM_W = 9;
  localparam int unsigned ACC_W  = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic              abort = 1'b0;
  logic [ELEM_W-1:0] in_a = '0;
  logic [ELEM_W-1:0] in_b = '0;
  logic              busy, in_ready, out_valid;
  logic [ACC_W-1:0]  out_data;
  int                total = 0;
  int                bad = 0;

  always #5 clk = ~clk;

  vec_dot_sequencer #(
    .LEN   (LEN),
    .LANES (LANES),
    .ELEM_W(ELEM_W),
    .ACC_W (ACC_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .busy     (busy),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef VPM_ABORT_EN
    ,
    .abort    (abort)
`endif
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 collecting pairs, 2 computing, 3 result offered.
  int               m_phase = 0;
  int               m_cnt = 0;
  logic [ACC_W-1:0] m_dot = '0;
  logic [ACC_W-1:0] m_out = '0;
  bit               m_abort;

  always @(posedge clk or negedge rst_n) begin
`ifdef VPM_ABORT_EN
    m_abort = abort;
`else
    m_abort = 1'b0;
`endif
    if (!rst_n) begin
      m_phase = 0;
      m_cnt   = 0;
      m_dot   = '0;
      m_out   = '0;
    end else if (m_abort && m_phase != 0) begin
      if (m_phase == 3) m_out = '0;
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_phase = 1;
          m_cnt   = 0;
          m_dot   = '0;
        end
        1: if (in_valid) begin
          m_dot = m_dot + ACC_W'(in_a) * ACC_W'(in_b);
          m_cnt++;
          if (m_cnt == int'(LEN)) begin
            m_phase = 2;
            m_cnt   = 0;
          end
        end
        2: begin
          m_cnt++;
          if (m_cnt == int'(LEN / LANES)) begin
            m_phase = 3;
            m_out   = m_dot;
          end
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  always @(posedge clk) begin
    #1;
    check("cyc_busy", busy, m_phase != 0);
    check("cyc_in_ready", in_ready, m_phase == 1);
    check("cyc_out_valid", out_valid, m_phase == 3);
    check("cyc_out_data", out_data, m_out);
  end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // kind 0: A=i+1,B=1  1: A=B=511  2: A=B=i+1  3: A=2,B=3
  task automatic load_vec(input int kind, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ((i % 3) + 1) @(negedge clk);
      in_valid = 1'b1;
      case (kind)
        0: begin in_a = ELEM_W'(i + 1); in_b = 1; end
        1: begin in_a = 511; in_b = 511; end
        2: begin in_a = ELEM_W'(i + 1); in_b = ELEM_W'(i + 1); end
        default: begin in_a = 2; in_b = 3; end
      endcase
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wait_out_valid", out_valid, 1'b1);
  endtask

  task automatic take_result(input logic [ACC_W-1:0] exp, input int hold, input bit start_too);
    check("result", out_data, exp);
    repeat (hold) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1'b1);
      check("hold_data", out_data, exp);
    end
    out_ready = 1'b1;
    start     = start_too;
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    check("after_hs_busy", busy, 1'b0);
    check("after_hs_valid", out_valid, 1'b0);
    check("after_hs_retain", out_data, exp);
    @(negedge clk);
    check("still_idle", busy, 1'b0);
  endtask

  initial begin
    int n;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic run with latency check
    do_start();
    check("load_in_ready", in_ready, 1'b1);
    load_vec(0, 8, 1'b0);
    wait_valid(n);
    check("latency", n, 4);
    take_result(36, 0, 1'b0);

    // Max values, start pulsed during COMPUTE
    do_start();
    load_vec(1, 8, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(n);
    take_result(32'd2088968, 0, 1'b0);

    // Input gaps, output backpressure, start during DONE handshake
    do_start();
    load_vec(2, 8, 1'b1);
    wait_valid(n);
    take_result(204, 5, 1'b1);

    // Asynchronous reset mid-LOAD
    do_start();
    load_vec(2, 3, 1'b0);
    check("pre_rst_busy", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_busy", busy, 1'b0);
    check("async_in_ready", in_ready, 1'b0);
    check("async_out_valid", out_valid, 1'b0);
    check("async_out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start();
    load_vec(3, 8, 1'b0);
    wait_valid(n);
    take_result(48, 0, 1'b0);

`ifdef VPM_ABORT_EN
    do_start();
    load_vec(0, 8, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    repeat (8) begin
      @(negedge clk);
      check("abort_no_valid", out_valid, 1'b0);
    end
    do_start();
    load_vec(0, 8, 1'b0);
    wait_valid(n);
    take_result(36, 0, 1'b0);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vec_dot_sequencer.md
Name: vec_dot_sequencer

Overview:
- Controller for the parallel vector multiplier datapath.
- Collects two LEN-element unsigned vectors over a valid/ready stream, then drives LANES parallel multipliers for LEN/LANES cycles and accumulates the products.
- Each product is 2*ELEM_W = 18 bits wide and is zero-extended to ACC_W = 32 bits before accumulation.
- Presents the 32-bit dot product on a valid/ready output to downstream logic.

Parameters:
- LEN, 8, elements per vector; must be a multiple of LANES, ≥ 2.
- LANES, 2, multipliers used per compute cycle.
- ELEM_W, 9, element width (unsigned); product width = 2*ELEM_W.
- ACC_W, 32, accumulator/result width; products zero-extended to ACC_W.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin new operation; sampled only in IDLE.
- busy  out  1  high whenever state != IDLE.
- in_valid  in  1  element pair valid.
- in_ready  out  1  sequencer accepts element pair.
- in_a  in  ELEM_W  vector A element.
- in_b  in  ELEM_W  vector B element.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  ACC_W  dot product.
- abort  in  1  present only with VPM_ABORT_EN.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, in_ready=0, out_valid=0, out_data=0; load index, compute index, accumulator and element buffers cleared.
- States: IDLE, LOAD, COMPUTE, DONE.
- IDLE:
  - start=1 → LOAD next edge; accumulator and indices cleared on that edge.
  - start in any other state is ignored.
- LOAD:
  - in_ready=1 (registered, high for the whole state).
  - Each cycle with in_valid&in_ready stores {in_a,in_b} at buffer[idx] and increments idx.
  - in_valid=0 stalls with no state change.
  - The handshake with idx=LEN-1 → COMPUTE; in_ready=0 from the next cycle.
- COMPUTE: exactly LEN/LANES cycles.
  - Cycle k adds sum over j<LANES of buffer_a[k*LANES+j]*buffer_b[k*LANES+j].
  - Addition is modulo 2^ACC_W (wrap; cannot occur at defaults).
  - After the last compute edge → DONE.
- DONE:
  - out_valid=1; out_data=accumulator, held stable until handshake.
  - out_valid&out_ready → IDLE; out_valid=0 next cycle; out_data retains last value.
- Latency: out_valid rises LEN/LANES cycles after the edge of the final LOAD handshake (4 cycles at defaults). The minimum start-to-result time is therefore LEN + LEN/LANES + 1 cycles.
- Simultaneous events:
  - start asserted during the DONE handshake cycle is ignored; at least one IDLE cycle is required between operations.
  - in_valid outside LOAD is ignored (in_ready=0).
- Reset mid-operation returns to IDLE immediately; partial data is discarded and the next operation is unaffected.

Optional Feature:
- Macro: VPM_ABORT_EN.
- Defined:
  - Adds port abort.
  - abort=1 in LOAD, COMPUTE or DONE → IDLE on the next edge.
  - Accumulator and indices are cleared, out_valid and in_ready drop next cycle, and no result is presented.
  - abort has priority over every other transition, including the DONE handshake. In that case the result is treated as consumed but out_data is cleared to 0.
  - abort in IDLE has no effect; start and abort together in IDLE → remains IDLE.
- Undefined: no abort port; behaviour is as above.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle → busy, in_ready and out_valid are 0 and out_data=0 immediately, without waiting for a clock edge.
- Basic: start; feed A=1..8, B=1 with in_valid continuous → 8 LOAD cycles; out_valid 4 cycles after the last handshake; out_data=36; out_ready=1 → IDLE, busy=0.
- Max values: A=B=511 for all 8 → out_data=2088968 (0x1FE008), no wrap.
- Backpressure: in_valid gaps of 1–3 cycles; A=B=i (i=1..8); hold out_ready=0 for 5 cycles → out_data=204 held stable with out_valid=1; release → handshake, IDLE.
- Ignored and reset cases:
  - start pulsed during COMPUTE and during the DONE handshake → no effect.
  - rst_n=0 after 3 LOAD handshakes → IDLE; a fresh run with A=2, B=3 → 48.
- With VPM_ABORT_EN: abort during COMPUTE → IDLE next edge, out_valid never rises; a following run with A=1..8, B=1 → 36.
